// File: rtl/bp_me_pkg.sv
// FSM state and load/store lane helpers for the cache-packet RAM.
package bp_me_pkg;

    typedef enum logic {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_me_cache_pkt_ram_state_e;

    typedef enum logic [1:0] {
        e_size_b = 2'd0,
        e_size_h = 2'd1,
        e_size_w = 2'd2,
        e_size_d = 2'd3
    } bp_me_size_e;

    // Misaligned accesses drop the low offset bits that break natural alignment.
    function automatic logic [2:0] align_offset(input logic [2:0] off, input bp_me_size_e size);
        case (size)
            e_size_b: return off;
            e_size_h: return {off[2:1], 1'b0};
            e_size_w: return {off[2], 2'b00};
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input bp_me_size_e size);
        case (size)
            e_size_b: return 8'h01;
            e_size_h: return 8'h03;
            e_size_w: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] store_replicate(input logic [63:0] data, input bp_me_size_e size);
        case (size)
            e_size_b: return {8{data[7:0]}};
            e_size_h: return {4{data[15:0]}};
            e_size_w: return {2{data[31:0]}};
            default:  return data;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] dword, input logic [2:0] off,
                                                input bp_me_size_e size, input logic sign);
        logic [63:0] sh;
        sh = dword >> {off, 3'b000};
        case (size)
            e_size_b: return {{56{sign & sh[7]}}, sh[7:0]};
            e_size_h: return {{48{sign & sh[15]}}, sh[15:0]};
            e_size_w: return {{32{sign & sh[31]}}, sh[31:0]};
            default:  return sh;
        endcase
    endfunction

endpackage

// File: rtl/bsg_cache_pkg.sv
// bsg_cache opcode encoding and packet-width helper shared by cache clients
// and stand-ins.
package bsg_cache_pkg;

    typedef enum logic [5:0] {
        LB      = 6'b000000,
        LH      = 6'b000001,
        LW      = 6'b000010,
        LD      = 6'b000011,
        LBU     = 6'b000100,
        LHU     = 6'b000101,
        LWU     = 6'b000110,
        LDU     = 6'b000111,
        SB      = 6'b001000,
        SH      = 6'b001001,
        SW      = 6'b001010,
        SD      = 6'b001011,
        LM      = 6'b001100,
        SM      = 6'b001101,
        TAGST   = 6'b010000,
        TAGFL   = 6'b010001,
        TAGLV   = 6'b010010,
        TAGLA   = 6'b010011,
        AFL     = 6'b011000,
        AFLINV  = 6'b011001,
        AINV    = 6'b011010,
        ALOCK   = 6'b011011,
        AUNLOCK = 6'b011100
    } bsg_cache_opcode_e;

    // Packet layout is {opcode, addr, data, mask}, mask being one bit per byte.
    function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
        return $bits(bsg_cache_opcode_e) + addr_width + data_width + (data_width >> 3);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables; read data is
// registered and holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter  int els_p               = 1024,
    parameter  int data_width_p        = 64,
    localparam int addr_width_lp       = $clog2(els_p),
    localparam int write_mask_width_lp = data_width_p / 8
) (
    input  logic                           clk_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]        data_o
);

    logic [data_width_p-1:0] r_mem [els_p];
    logic [data_width_p-1:0] r_data;

    // NOTE: storage has no reset; clearing a RAM array would force it into
    // flops, and callers never read a location they have not written.
    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int i = 0; i < write_mask_width_lp; i++) begin
                if (write_mask_i[i]) r_mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
            end
        end
        if (v_i & ~w_i) r_data <= r_mem[addr_i];
    end

    assign data_o = r_data;

endmodule

// File: rtl/bp_me_cache_pkt_ram.sv
// bsg_cache stand-in: one bsg_cache packet in, one response out, backed by a
// byte-maskable single-port RAM.
module bp_me_cache_pkt_ram
    import bsg_cache_pkg::*;
    import bp_me_pkg::*;
#(
    parameter  int paddr_width_p      = 40,
    parameter  int dword_width_p      = 64,
    parameter  int mem_els_p          = 1024,
    localparam int cache_pkt_width_lp = bsg_cache_pkt_width(paddr_width_p, dword_width_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [cache_pkt_width_lp-1:0] cache_pkt_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [dword_width_p-1:0]      data_o,
    output logic                          v_o,
    input  logic                          yumi_i,
    output logic                          error_o
);

    localparam int idx_width_lp  = $clog2(mem_els_p);
    localparam int mask_width_lp = dword_width_p / 8;

    typedef struct packed {
        bsg_cache_opcode_e          opcode;
        logic [paddr_width_p-1:0]   addr;
        logic [dword_width_p-1:0]   data;
        logic [mask_width_lp-1:0]   mask;
    } cache_pkt_s;

    cache_pkt_s                 w_pkt;
    bp_me_cache_pkt_ram_state_e r_state, w_state_n;
    logic                       w_accept;

    logic                       w_is_load, w_is_store, w_is_masked, w_illegal, w_sign;
    bp_me_size_e                w_size;
    logic [2:0]                 w_off_al;
    logic [mask_width_lp-1:0]   w_wmask;
    logic [dword_width_p-1:0]   w_wdata, w_mem_data, w_resp_data;

    logic                       r_load, r_sign, r_capture, r_error;
    bp_me_size_e                r_size;
    logic [2:0]                 r_off;
    logic [dword_width_p-1:0]   r_data;

    logic                       w_unused_addr;

    assign w_pkt         = cache_pkt_s'(cache_pkt_i);
    assign w_unused_addr = ^w_pkt.addr[paddr_width_p-1:3+idx_width_lp];

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one holding its old value as a latch.
    always_comb begin
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_masked = 1'b0;
        w_illegal   = 1'b0;
        w_sign      = 1'b0;
        w_size      = e_size_d;
        unique case (w_pkt.opcode)
            TAGST: ;
            LB:  begin w_is_load  = 1'b1; w_size = e_size_b; w_sign = 1'b1; end
            LH:  begin w_is_load  = 1'b1; w_size = e_size_h; w_sign = 1'b1; end
            LW:  begin w_is_load  = 1'b1; w_size = e_size_w; w_sign = 1'b1; end
            LBU: begin w_is_load  = 1'b1; w_size = e_size_b; end
            LHU: begin w_is_load  = 1'b1; w_size = e_size_h; end
            LWU: begin w_is_load  = 1'b1; w_size = e_size_w; end
            LD, LM: w_is_load = 1'b1;
            SB:  begin w_is_store = 1'b1; w_size = e_size_b; end
            SH:  begin w_is_store = 1'b1; w_size = e_size_h; end
            SW:  begin w_is_store = 1'b1; w_size = e_size_w; end
            SD:  w_is_store = 1'b1;
            SM:  begin w_is_store = 1'b1; w_is_masked = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
        w_off_al = align_offset(w_pkt.addr[2:0], w_size);
        w_wmask  = w_is_masked ? w_pkt.mask : (size_mask(w_size) << w_off_al);
        w_wdata  = store_replicate(w_pkt.data, w_size);
    end

    always_comb begin
        w_state_n = r_state;
        ready_o   = 1'b0;
        v_o       = 1'b0;
        case (r_state)
            e_ready: begin
                ready_o = 1'b1;
                if (v_i) w_state_n = e_resp;
            end
            e_resp: begin
                v_o = 1'b1;
                if (yumi_i) w_state_n = e_ready;
            end
            default: w_state_n = e_ready;
        endcase
    end

    assign w_accept = v_i & ready_o;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (dword_width_p)
    ) u_mem (
        .clk_i        (clk_i),
        .v_i          (w_accept & (w_is_load | w_is_store)),
        .w_i          (w_is_store),
        .addr_i       (w_pkt.addr[3 +: idx_width_lp]),
        .data_i       (w_wdata),
        .write_mask_i (w_wmask),
        .data_o       (w_mem_data)
    );

    assign w_resp_data = r_load ? load_extend(w_mem_data, r_off, r_size, r_sign) : '0;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= e_ready;
            r_load    <= 1'b0;
            r_sign    <= 1'b0;
            r_size    <= e_size_d;
            r_off     <= 3'b000;
            r_capture <= 1'b0;
            r_data    <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_load    <= w_is_load;
                r_sign    <= w_sign;
                r_size    <= w_size;
                r_off     <= w_off_al;
                r_capture <= 1'b1;
                if (w_illegal) r_error <= 1'b1;
            end else if (r_capture) begin
                r_data    <= w_resp_data;
                r_capture <= 1'b0;
            end
        end
    end

    // RAM output is live only in the first response cycle; afterwards the
    // captured copy keeps data_o stable while the consumer stalls.
    assign data_o  = r_capture ? w_resp_data : r_data;
    assign error_o = r_error;

endmodule

// File: tb/tb_bp_me_cache_pkt_ram.sv
// Directed bench for bp_me_cache_pkt_ram with a response scoreboard queue.
module tb_bp_me_cache_pkt_ram;
    import bsg_cache_pkg::*;

    localparam int pkt_w = bsg_cache_pkt_width(40, 64);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [pkt_w-1:0] cache_pkt = '0;
    logic             v_i = 1'b0;
    logic             ready_o;
    logic [63:0]      data_o;
    logic             v_o;
    logic             yumi_i = 1'b0;
    logic             error_o;

    int               checks = 0;
    int               failures = 0;
    logic [63:0]      exp_q[$];

    always #5 clk = ~clk;

    bp_me_cache_pkt_ram dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cache_pkt_i (cache_pkt),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .error_o     (error_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full packet: drive, wait for accept, wait for response, optionally
    // stall the consumer while offering a competing packet, then compare.
    task automatic txn(input string tag, input bsg_cache_opcode_e op, input logic [39:0] addr,
                       input logic [63:0] data, input logic [7:0] mask,
                       input logic [63:0] exp, input int hold = 0);
        int          n;
        logic [63:0] first;
        logic [63:0] e;
        @(negedge clk);
        cache_pkt = {op, addr, data, mask};
        v_i = 1'b1;
        exp_q.push_back(exp);
        n = 0;
        while (!ready_o && n < 50) begin @(negedge clk); n++; end
        check({tag, "_ready_in"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        v_i = 1'b0;
        n = 0;
        while (!v_o && n < 50) begin @(negedge clk); n++; end
        check({tag, "_v_o"}, 64'(v_o), 64'd1);
        check({tag, "_busy"}, 64'(ready_o), 64'd0);
        first = data_o;
        for (int i = 0; i < hold; i++) begin
            cache_pkt = {SD, 40'h300, 64'hDEAD, 8'hFF};
            v_i = 1'b1;
            @(negedge clk);
            check({tag, "_hold_v"}, 64'(v_o), 64'd1);
            check({tag, "_hold_ready"}, 64'(ready_o), 64'd0);
            check({tag, "_hold_data"}, data_o, first);
        end
        v_i = 1'b0;
        e = exp_q.pop_front();
        check(tag, data_o, e);
        yumi_i = 1'b1;
        @(negedge clk);
        yumi_i = 1'b0;
        check({tag, "_idle_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_idle_v"}, 64'(v_o), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_v", 64'(v_o), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready_o), 64'd1);
        check("post_rst_v", 64'(v_o), 64'd0);
        check("post_rst_data", data_o, 64'd0);
        check("post_rst_err", 64'(error_o), 64'd0);

        for (int a = 0; a < 64; a++) txn("tagst", TAGST, 40'(a), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0);

        txn("sd_100",   SD,  40'h100, 64'h8877665544332211, 8'h00, 64'd0);
        txn("lb_107",   LB,  40'h107, 64'd0, 8'h00, 64'hFFFFFFFFFFFFFF88);
        txn("lbu_107",  LBU, 40'h107, 64'd0, 8'h00, 64'h0000000000000088);
        txn("lh_102",   LH,  40'h102, 64'd0, 8'h00, 64'h0000000000004433);
        txn("lw_104",   LW,  40'h104, 64'd0, 8'h00, 64'hFFFFFFFF88776655);
        txn("lhu_106",  LHU, 40'h106, 64'd0, 8'h00, 64'h0000000000008877);
        txn("lwu_104",  LWU, 40'h104, 64'd0, 8'h00, 64'h0000000088776655);
        txn("lh_103",   LH,  40'h103, 64'd0, 8'h00, 64'h0000000000004433);
        txn("sb_101",   SB,  40'h101, 64'h00000000000000AB, 8'h00, 64'd0);
        txn("ld_100a",  LD,  40'h100, 64'd0, 8'h00, 64'h887766554433AB11);
        txn("sh_105",   SH,  40'h105, 64'h000000000000CDEF, 8'h00, 64'd0);
        txn("ld_100b",  LD,  40'h100, 64'd0, 8'h00, 64'h8877CDEF4433AB11);
        txn("lh_104",   LH,  40'h104, 64'd0, 8'h00, 64'hFFFFFFFFFFFFCDEF);

        txn("sd_200",   SD,  40'h200, 64'd0, 8'h00, 64'd0);
        txn("sm_200",   SM,  40'h200, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'd0);
        txn("lm_200",   LM,  40'h200, 64'd0, 8'h00, 64'h00000000FFFFFFFF);
        txn("sd_208",   SD,  40'h208, 64'd0, 8'h00, 64'd0);
        txn("sw_20b",   SW,  40'h20B, 64'hFFFFFFFF12345678, 8'h00, 64'd0);
        txn("ld_208",   LD,  40'h208, 64'd0, 8'h00, 64'h0000000012345678);

        txn("sd_300",   SD,  40'h300, 64'h1111, 8'h00, 64'd0);
        txn("ld_hold",  LD,  40'h100, 64'd0, 8'h00, 64'h8877CDEF4433AB11, 10);
        txn("ld_300",   LD,  40'h300, 64'd0, 8'h00, 64'h1111);

        txn("sd_2000",  SD,  40'h2000, 64'h0123456789ABCDEF, 8'h00, 64'd0);
        txn("ld_wrap",  LD,  40'h0, 64'd0, 8'h00, 64'h0123456789ABCDEF);

        // Reset in the middle of a response.
        @(negedge clk);
        cache_pkt = {LD, 40'h100, 64'd0, 8'h00};
        v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        check("pre_rst_v", 64'(v_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_drop_v", 64'(v_o), 64'd0);
        check("async_ready", 64'(ready_o), 64'd1);
        check("async_data", data_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_v_after_rst", 64'(v_o), 64'd0);
            check("ready_after_rst", 64'(ready_o), 64'd1);
        end

        txn("illegal_tagfl", TAGFL, 40'h100, 64'hFFFF, 8'hFF, 64'd0);
        check("err_set", 64'(error_o), 64'd1);
        txn("ld_after_err", LD, 40'h0, 64'd0, 8'h00, 64'h0123456789ABCDEF);
        check("err_sticky", 64'(error_o), 64'd1);
        txn("illegal_afl", AFL, 40'h0, 64'd0, 8'h00, 64'd0);
        txn("ld_0_keep",   LD,  40'h0, 64'd0, 8'h00, 64'h0123456789ABCDEF);
        check("err_still", 64'(error_o), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("err_cleared", 64'(error_o), 64'd0);
        check("q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_me_cache_pkt_ram.md
BP_ME_CACHE_PKT_RAM -- requirements
Module: bp_me_cache_pkt_ram

Interface
- REQ-001: Parameter paddr_width_p, default 40, physical address width of cache_pkt_i.addr.
- REQ-002: Parameter dword_width_p, default 64, data width; only 64 is supported.
- REQ-003: Parameter mem_els_p, default 1024, RAM depth in dwords; must be a power of 2.
- REQ-004: Port clk_i, input, 1, the single clock; all logic is rising-edge.
- REQ-005: Port reset_n_i, input, 1, asynchronous active-low reset.
- REQ-006: Port cache_pkt_i, input, bsg_cache_pkt_width(paddr_width_p,dword_width_p), bsg_cache packet carrying opcode, addr, data and mask.
- REQ-007: Port v_i, input, 1, cache_pkt_i is valid.
- REQ-008: Port ready_o, output, 1, block accepts a packet this cycle.
- REQ-009: Port data_o, output, dword_width_p, response data.
- REQ-010: Port v_o, output, 1, data_o is valid.
- REQ-011: Port yumi_i, input, 1, consumer takes data_o this cycle.
- REQ-012: Port error_o, output, 1, sticky flag set on an unsupported opcode.

Function
- REQ-013: The block is a drop-in bsg_cache stand-in that consumes bp_me_cce_to_cache output; exactly one response is produced per accepted packet, in acceptance order.
- REQ-014: FSM states are e_ready and e_resp; reset state is e_ready.
- REQ-015: ready_o = (state==e_ready). A packet is accepted when v_i & ready_o, and the FSM then moves to e_resp.
- REQ-016: In e_resp, v_o=1. On yumi_i the FSM returns to e_ready; ready_o does not depend on yumi_i, so minimum throughput is one packet per 2 cycles.
- REQ-017: RAM index = addr[3 +: log2(mem_els_p)]; higher address bits are ignored, so addresses wrap modulo mem_els_p*8 bytes. Byte offset = addr[2:0].
- REQ-018: The RAM is accessed only in the accept cycle. Read data appears the next cycle and is captured into a response register that holds stable until yumi_i.
- REQ-019: TAGST writes nothing and responds with data_o=0.
- REQ-020: LB, LH and LW select the naturally aligned byte, half or word at the byte offset and sign-extend it to 64 bits. LBU, LHU and LWU zero-extend. LD and LM return the full dword.
- REQ-021: SB, SH and SW write data[7:0], [15:0] or [31:0] into the byte lanes at the byte offset. SD writes all lanes. SM writes the lanes selected by mask. All stores respond with data_o=0.
- REQ-022: Misaligned LH, LW, SH and SW ignore the low offset bits that break alignment.
- REQ-023: Any other opcode writes nothing, responds with data_o=0, and sets error_o, which stays set until reset.
- REQ-024: A store followed by a load to the same index returns the stored data (read-after-write visible with no extra latency).
- REQ-025: When v_i=1 in e_resp, the packet is not accepted and must be held by the sender.

Reset
- REQ-026: Asserting reset_n_i low immediately forces state to e_ready, ready_o=1 after release, v_o=0, data_o register=0 and error_o=0.
- REQ-027: RAM contents are not reset; reads before any write return X in simulation.
- REQ-028: Reset asserted mid-response discards the pending response, and no v_o pulse follows the release.

Structure
- REQ-029: Opcodes and the packet struct are taken from bsg_cache_pkg / declare_bsg_cache_pkt_s; no new package types are added.
- REQ-030: The FSM state enum and the extend/select helper constants live in bp_me_pkg.
- REQ-031: Storage is one sub-module instance of bsg_mem_1rw_sync_mask_write_byte (els mem_els_p, data width dword_width_p).

Verification
- REQ-032: After reset, send TAGST addr 0x0 through 0x3F; each packet yields one v_o with data_o=0, and ready_o is low for exactly the e_resp cycles.
- REQ-033: SD addr 0x100 data 0x8877665544332211, then LB addr 0x107 -> 0xFFFFFFFFFFFFFF88; LBU 0x107 -> 0x88; LH 0x102 -> 0x4433; LW 0x104 -> 0xFFFFFFFF88776655.
- REQ-034: SM addr 0x200 data all-ones mask 0x0F over prior 0, then LM 0x200 -> 0x00000000FFFFFFFF.
- REQ-035: Hold yumi_i=0 for 10 cycles after a load; data_o stays stable, v_o stays 1, ready_o stays 0, and a new v_i is not accepted.
- REQ-036: With mem_els_p=1024, SD to addr 0x2000 then LD addr 0x0 returns the same data (wrap).
- REQ-037: Assert reset_n_i low while in e_resp -> v_o drops asynchronously; issue an illegal opcode -> error_o=1, which persists until the next reset.
